ram_arbiter: RTL and testbench

// Shares the single-port unified instruction/data RAM between two requesters:
// the controller's instruction-fetch port (IF, read-only) and the load/store

---
 rtl/arm_mem_pkg.sv | 10 +
 rtl/arb_pick.sv | 21 ++
 rtl/ram_arbiter.sv | 175 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/arm_mem_pkg.sv
// rtl/arm_mem_pkg.sv - shared types and defaults for the RAM arbiter
package arm_mem_pkg;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {IDLE, GNT, WAIT, RESP} arb_state_t;
    typedef enum logic {PORT_IF, PORT_DM} port_t;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational IF/DM winner selection with last-grant fairness
import arm_mem_pkg::*;

module arb_pick (
    input  logic  if_req,
    input  logic  dm_req,
    input  port_t last_gnt,
    output logic  gnt_valid,
    output port_t gnt_port
);

    always_comb begin
        gnt_valid = if_req | dm_req;
        gnt_port  = PORT_IF;
        // DM has priority on a tie unless it won the previous grant
        if (dm_req && !(if_req && last_gnt == PORT_DM)) begin
            gnt_port = PORT_DM;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port RAM arbiter between instruction fetch and data ports
import arm_mem_pkg::*;

module ram_arbiter #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_w_en,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    arb_state_t        state_q, state_d;
    port_t             win_q, win_d;
    port_t             last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_w_en_q, ram_w_en_d;
    logic              if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
    logic              if_valid_q, if_valid_d, dm_valid_q, dm_valid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic              busy_q, busy_d;

    logic  pick_valid;
    port_t pick_port;

    arb_pick u_pick (
        .if_req    (if_req),
        .dm_req    (dm_req),
        .last_gnt  (last_gnt_q),
        .gnt_valid (pick_valid),
        .gnt_port  (pick_port)
    );

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        last_gnt_d  = last_gnt_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_w_en_d  = 1'b0;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = GNT;
                    win_d      = pick_port;
                    last_gnt_d = pick_port;
                    cnt_d      = CNT_W'(RD_LAT - 1);
                    if (pick_port == PORT_DM) begin
                        ram_addr_d  = dm_addr;
                        we_d        = dm_we;
                        ram_w_en_d  = dm_we;
                        ram_wdata_d = dm_we ? dm_wdata : '0;
                        dm_gnt_d    = 1'b1;
                    end else begin
                        ram_addr_d  = if_addr;
                        we_d        = 1'b0;
                        ram_wdata_d = '0;
                        if_gnt_d    = 1'b1;
                    end
                end
            end
            GNT: begin
                if (we_q) begin
                    state_d     = IDLE;
                    ram_addr_d  = '0;
                    ram_wdata_d = '0;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // ram_rdata is valid in the last WAIT cycle; register it so valid and data align
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (win_q == PORT_DM) begin
                        dm_rdata_d = ram_rdata;
                        dm_valid_d = 1'b1;
                    end else begin
                        if_rdata_d = ram_rdata;
                        if_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d     = IDLE;
                ram_addr_d  = '0;
                ram_wdata_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            win_q       <= PORT_IF;
            last_gnt_q  <= PORT_IF;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_w_en_q  <= 1'b0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            last_gnt_q  <= last_gnt_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_w_en_q  <= ram_w_en_d;
            if_gnt_q    <= if_gnt_d;
            dm_gnt_q    <= dm_gnt_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign dm_gnt    = dm_gnt_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_w_en  = ram_w_en_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with RD_LAT=1 RAM model
module tb_ram_arbiter;

    localparam int RAND_N = 400;

    logic        clk, rst_n;
    logic        if_req, if_gnt, if_valid;
    logic [10:0] if_addr;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_valid;
    logic [10:0] dm_addr;
    logic [31:0] dm_wdata, dm_rdata;
    logic [10:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        ram_w_en, busy;
    logic [5:0]  flags;

    logic [31:0] mem [0:2047];
    logic [31:0] shadow [0:7];
    int          errors = 0;
    int          checks = 0;

    ram_arbiter #(.ADDR_W(11), .DATA_W(32), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_w_en(ram_w_en), .ram_rdata(ram_rdata),
        .busy(busy)
    );

    assign flags = {if_gnt, if_valid, dm_gnt, dm_valid, ram_w_en, busy};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (ram_w_en) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        logic        rst_n, ifr;
        logic [10:0] ifa;
        logic        dmr, dwe;
        logic [10:0] dma;
        logic [31:0] dwd;
        logic [5:0]  ef;
        logic [10:0] ea;
        logic [31:0] ed;
    } vec_t;

    function automatic vec_t mk(logic r, logic ifr, logic [10:0] ifa, logic dmr, logic dwe,
                                logic [10:0] dma, logic [31:0] dwd, logic [5:0] ef,
                                logic [10:0] ea, logic [31:0] ed);
        vec_t v;
        v.rst_n = r; v.ifr = ifr; v.ifa = ifa; v.dmr = dmr; v.dwe = dwe;
        v.dma = dma; v.dwd = dwd; v.ef = ef; v.ea = ea; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    vec_t        tbl [22];
    int          order [$];
    logic [5:0]  exp_flags [RAND_N+8];
    logic [31:0] exp_data [RAND_N+8];
    int          next_s;
    logic        last_dm, win_dm;

    initial begin
        for (int a = 0; a < 2048; a++) mem[a] = 32'h0;
        mem[11'h004] = 32'hE3A00008;
        mem[11'h010] = 32'h00001234;
        for (int j = 0; j < 8; j++) begin
            mem[11'h030 + 11'(j)] = 32'hA5A50000 + 32'(j);
            shadow[j]             = 32'hA5A50000 + 32'(j);
        end
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

        // flags = {if_gnt, if_valid, dm_gnt, dm_valid, ram_w_en, busy}
        tbl[0]  = mk(0, 0, 11'h000, 0, 0, 11'h000, 32'h0,        6'b000000, 11'h000, 32'h0);
        tbl[1]  = mk(0, 0, 11'h000, 0, 0, 11'h000, 32'h0,        6'b000000, 11'h000, 32'h0);
        tbl[2]  = mk(0, 1, 11'h004, 1, 0, 11'h010, 32'h0,        6'b000000, 11'h000, 32'h0);
        tbl[3]  = mk(0, 0, 11'h000, 0, 0, 11'h000, 32'h0,        6'b000000, 11'h000, 32'h0);
        tbl[4]  = mk(1, 1, 11'h004, 0, 0, 11'h000, 32'h0,        6'b100001, 11'h004, 32'h0);
        tbl[5]  = mk(1, 0, 11'h000, 0, 0, 11'h000, 32'h0,        6'b000001, 11'h004, 32'h0);
        tbl[6]  = mk(1, 0, 11'h000, 0, 0, 11'h000, 32'h0,        6'b010001, 11'h004, 32'hE3A00008);
        tbl[7]  = mk(1, 0, 11'h000, 0, 0, 11'h000, 32'h0,        6'b000000, 11'h000, 32'h0);
        tbl[8]  = mk(1, 1, 11'h004, 1, 0, 11'h010, 32'h0,        6'b001001, 11'h010, 32'h0);
        tbl[9]  = mk(1, 1, 11'h004, 0, 0, 11'h000, 32'h0,        6'b000001, 11'h010, 32'h0);
        tbl[10] = mk(1, 1, 11'h004, 0, 0, 11'h000, 32'h0,        6'b000101, 11'h010, 32'h00001234);
        tbl[11] = mk(1, 1, 11'h004, 0, 0, 11'h000, 32'h0,        6'b000000, 11'h000, 32'h0);
        tbl[12] = mk(1, 1, 11'h004, 0, 0, 11'h000, 32'h0,        6'b100001, 11'h004, 32'h0);
        tbl[13] = mk(1, 0, 11'h000, 0, 0, 11'h000, 32'h0,        6'b000001, 11'h004, 32'h0);
        tbl[14] = mk(1, 0, 11'h000, 0, 0, 11'h000, 32'h0,        6'b010001, 11'h004, 32'hE3A00008);
        tbl[15] = mk(1, 0, 11'h000, 0, 0, 11'h000, 32'h0,        6'b000000, 11'h000, 32'h0);
        tbl[16] = mk(1, 0, 11'h000, 1, 1, 11'h020, 32'hDEADBEEF, 6'b001011, 11'h020, 32'hDEADBEEF);
        tbl[17] = mk(1, 0, 11'h000, 0, 0, 11'h000, 32'h0,        6'b000000, 11'h000, 32'h0);
        tbl[18] = mk(1, 0, 11'h000, 1, 0, 11'h020, 32'h0,        6'b001001, 11'h020, 32'h0);
        tbl[19] = mk(1, 0, 11'h000, 0, 0, 11'h000, 32'h0,        6'b000001, 11'h020, 32'h0);
        tbl[20] = mk(1, 0, 11'h000, 0, 0, 11'h000, 32'h0,        6'b000101, 11'h020, 32'hDEADBEEF);
        tbl[21] = mk(1, 0, 11'h000, 0, 0, 11'h000, 32'h0,        6'b000000, 11'h000, 32'h0);

        for (int i = 0; i < 22; i++) begin
            rst_n = tbl[i].rst_n; if_req = tbl[i].ifr; if_addr = tbl[i].ifa;
            dm_req = tbl[i].dmr; dm_we = tbl[i].dwe; dm_addr = tbl[i].dma; dm_wdata = tbl[i].dwd;
            tick();
            chk($sformatf("vec%0d_flags", i), 32'(flags), 32'(tbl[i].ef));
            chk($sformatf("vec%0d_ram_addr", i), 32'(ram_addr), 32'(tbl[i].ea));
            if (tbl[i].ef[4]) chk($sformatf("vec%0d_if_rdata", i), if_rdata, tbl[i].ed);
            if (tbl[i].ef[2]) chk($sformatf("vec%0d_dm_rdata", i), dm_rdata, tbl[i].ed);
            if (tbl[i].ef[1]) chk($sformatf("vec%0d_ram_wdata", i), ram_wdata, tbl[i].ed);
        end
        dm_req = 1'b0; dm_we = 1'b0;

        // Fairness: both held after reset, grants must alternate starting with DM
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        if_req = 1'b1; if_addr = 11'h004; dm_req = 1'b1; dm_addr = 11'h010;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (dm_gnt) order.push_back(1);
            if (if_gnt) order.push_back(0);
        end
        if_req = 1'b0; dm_req = 1'b0;
        chk("fair_count", 32'(order.size()), 32'd4);
        for (int j = 0; j < order.size() && j < 4; j++)
            chk($sformatf("fair_order%0d", j), 32'(order[j]), (j % 2 == 0) ? 32'd1 : 32'd0);
        tick(); tick();

        // Reset during WAIT drops the fetch response
        if_req = 1'b1; if_addr = 11'h004;
        tick();
        chk("midrst_gnt", 32'(flags), 32'b100001);
        if_req = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_reset", 32'(flags), 32'b000000);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("midrst_quiet%0d", c), 32'(flags), 32'b000000);
        end
        chk("midrst_rdata_cleared", if_rdata, 32'h0);
        if_req = 1'b1;
        tick();
        chk("after_rst_gnt", 32'(flags), 32'b100001);
        if_req = 1'b0;
        tick(); tick();
        chk("after_rst_valid", 32'(flags), 32'b010001);
        chk("after_rst_data", if_rdata, 32'hE3A00008);
        tick();

        // Randomized traffic against a transaction-level schedule model
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int i = 0; i < RAND_N + 8; i++) begin
            exp_flags[i] = '0;
            exp_data[i]  = '0;
        end
        next_s  = 0;
        last_dm = 1'b0;
        for (int i = 0; i < RAND_N; i++) begin
            if (i >= next_s && (if_req || dm_req)) begin
                win_dm  = dm_req && !(if_req && last_dm);
                last_dm = win_dm;
                if (win_dm && dm_we) begin
                    exp_flags[i] |= 6'b001011;
                    shadow[dm_addr[2:0]] = dm_wdata;
                    next_s = i + 2;
                end else begin
                    exp_flags[i]   |= win_dm ? 6'b001001 : 6'b100001;
                    exp_flags[i+1] |= 6'b000001;
                    exp_flags[i+2] |= win_dm ? 6'b000101 : 6'b010001;
                    exp_data[i+2]   = shadow[win_dm ? dm_addr[2:0] : if_addr[2:0]];
                    next_s = i + 4;
                end
            end
            tick();
            chk($sformatf("rnd%0d_flags", i), 32'(flags), 32'(exp_flags[i]));
            if (exp_flags[i][4]) chk($sformatf("rnd%0d_if_rdata", i), if_rdata, exp_data[i]);
            if (exp_flags[i][2]) chk($sformatf("rnd%0d_dm_rdata", i), dm_rdata, exp_data[i]);
            if (exp_flags[i][5]) if_req = 1'b0;
            if (exp_flags[i][3]) dm_req = 1'b0;
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = 11'h030 | 11'($urandom_range(0, 7));
            end
            if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req   = 1'b1;
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = 11'h030 | 11'($urandom_range(0, 7));
                dm_wdata = $urandom;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
